image_pattern_gen: RTL and testbench
====================================

IMAGE_PATTERN_GEN -- requirements
Module: image_pattern_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 768, meaning active pixels per line; it SHALL be a multiple of PPC and of 8.
REQ-002 SHALL have parameter IMG_H, default 512, meaning active lines per frame, at least 1.
REQ-003 SHALL have parameter PPC, default 2, meaning pixels per clock beat, range 1..8.
REQ-004 SHALL have parameter DW, default 8, meaning bits per colour component, range 4..16.
REQ-005 SHALL have parameter HBLANK, default 160, meaning idle cycles between lines, at least 1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named HCLK and HRESETn.
REQ-007 HCLK  input  1  clock; all state changes on the rising edge.
REQ-008 HRESETn  input  1  asynchronous active-low reset.
REQ-009 start  input  1  frame request; sampled only in IDLE.
REQ-010 mode  input  2  pattern select; latched on an accepted start.
REQ-011 VSYNC  output  1  one-cycle frame-start pulse.
REQ-012 HSYNC  output  1  high on every valid pixel beat.
REQ-013 DATA_R, DATA_G, DATA_B  output  PPC*DW each  pixel lanes; lane k = bits [k*DW +: DW], holding pixel x = col*PPC+k.
REQ-014 busy  output  1  high from the accepted start through the last blank/active cycle.
REQ-015 ctrl_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, VS, ACTIVE, HBL and DONE.
REQ-017 Transitions SHALL be: IDLE->VS when start=1; VS->ACTIVE after 1 cycle; ACTIVE->HBL at the last beat of a line if it is not the last line; ACTIVE->DONE at the last beat of the last line; HBL->ACTIVE after HBLANK cycles; DONE->IDLE after 1 cycle.
REQ-018 All outputs SHALL be registered; VSYNC SHALL be 1 only in VS, HSYNC 1 only in ACTIVE, ctrl_done 1 only in DONE, and busy 1 in VS/ACTIVE/HBL.
REQ-019 Latency: start=1 in IDLE at edge N SHALL give VSYNC=1 in the cycle after edge N, with the first HSYNC beat in the next cycle.
REQ-020 The column counter SHALL run 0..IMG_W/PPC-1 and the row counter 0..IMG_H-1; both SHALL clear in VS; the column SHALL wrap to 0 and the row increment at each line end.
REQ-021 Total cycles from VSYNC through the last HSYNC beat SHALL be 1 + IMG_H*(IMG_W/PPC) + (IMG_H-1)*HBLANK, followed by exactly one ctrl_done cycle.
REQ-022 mode 0 (gradient) SHALL give R = x mod 2^DW, G = row mod 2^DW, B = (x+row) mod 2^DW, truncated, with no saturation.
REQ-023 mode 1 (colour bars): with bar b = x/(IMG_W/8), R/G/B SHALL be all-ones if bit 2/1/0 of b is set, else 0.
REQ-024 mode 2 (checker): all three components SHALL be all-ones when ((x>>3) XOR (row>>3)) bit 0 is 1, else 0.
REQ-025 mode 3 (flat) SHALL give all components = 2^(DW-1).
REQ-026 DATA_R, DATA_G and DATA_B SHALL be 0 whenever HSYNC=0.
REQ-027 start SHALL be ignored while busy or in DONE; mode changes after acceptance SHALL NOT affect the current frame.
REQ-028 start held high continuously SHALL begin a new frame in the cycle after DONE, i.e. IDLE lasts 1 cycle.

Reset
REQ-029 With HRESETn=0 (asynchronous), the state SHALL be IDLE, all counters 0, the latched mode 0, and VSYNC, HSYNC, busy, ctrl_done and all DATA outputs 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no ctrl_done pulse; after release the block SHALL wait for a new start.

Verification (IMG_W=8, IMG_H=2, PPC=2, DW=8, HBLANK=2 unless noted)
REQ-031 One start pulse, mode 0 -> VSYNC 1 cycle, 4 HSYNC beats, 2 blank cycles, 4 beats, then ctrl_done 1 cycle (11 cycles VSYNC..last beat); line 1 beat 0 gives R=0x01_00 (lanes 1,0), G=0x01_01, B=0x02_01.
REQ-032 mode 1, IMG_W=16, PPC=2 -> beat 0 R/G/B=0x0000; beat 7 (x=14,15, bar 7) R=G=B=0xFFFF.
REQ-033 mode 2, IMG_W=16, IMG_H=9, PPC=1 -> row 0 x=8 gives 0xFF; row 8 x=8 gives 0x00; row 8 x=0 gives 0xFF.
REQ-034 start pulsed during ACTIVE with mode changed to 3 -> frame continues in mode 0, only one ctrl_done; a later start in IDLE produces all components 0x80.
REQ-035 HRESETn low at the 3rd HSYNC beat -> all outputs 0 immediately (before the next edge), no ctrl_done; start after release produces a complete frame from row 0, column 0.
REQ-036 start held at 1 -> back-to-back frames, each ctrl_done followed by IDLE for 1 cycle, then VSYNC.

Source files
------------

// File: rtl/image_pattern_gen.sv
// image_pattern_gen: streaming test-pattern source (gradient, colour bars, checker, flat)
// framed by a one-cycle VSYNC, HSYNC on every active beat and a ctrl_done pulse per frame.
module image_pattern_gen #(
    parameter int IMG_W  = 768,
    parameter int IMG_H  = 512,
    parameter int PPC    = 2,
    parameter int DW     = 8,
    parameter int HBLANK = 160
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [PPC*DW-1:0] DATA_R,
    output logic [PPC*DW-1:0] DATA_G,
    output logic [PPC*DW-1:0] DATA_B,
    output logic              busy,
    output logic              ctrl_done
);
    localparam int COLS = IMG_W / PPC;
    localparam int CW   = COLS > 1 ? $clog2(COLS) : 1;
    localparam int RW   = IMG_H > 1 ? $clog2(IMG_H) : 1;
    localparam int HW   = HBLANK > 1 ? $clog2(HBLANK) : 1;
    localparam int BAR  = IMG_W / 8;
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, VS, ACTIVE, HBL, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [PPC*DW-1:0] r_d, g_d, b_d;
    logic [3*DW-1:0]   pix_d;

    function automatic logic [3*DW-1:0] pixel(input logic [1:0] m, input int x, input int y);
        pixel = m == 2'd0 ? {DW'(x), DW'(y), DW'(x + y)} :
                m == 2'd1 ? {{DW{((x / BAR) & 4) != 0}}, {DW{((x / BAR) & 2) != 0}},
                             {DW{((x / BAR) & 1) != 0}}} :
                m == 2'd2 ? {(3*DW){(((x ^ y) >> 3) & 1) != 0}} : {3{HALF}};
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hcnt_d  = hcnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = VS;
                mode_d  = mode;
            end
            VS: begin
                state_d = ACTIVE;
                col_d   = '0;
                row_d   = '0;
            end
            ACTIVE: begin
                col_d = col_q == CW'(COLS - 1) ? '0 : col_q + 1'b1;
                if (col_q == CW'(COLS - 1)) begin
                    state_d = row_q == RW'(IMG_H - 1) ? DONE : HBL;
                    row_d   = row_q == RW'(IMG_H - 1) ? row_q : row_q + 1'b1;
                    hcnt_d  = '0;
                end
            end
            HBL: begin
                state_d = hcnt_q == HW'(HBLANK - 1) ? ACTIVE : HBL;
                hcnt_d  = hcnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixels are computed for the beat about to be presented so DATA is registered with HSYNC.
    always_comb begin
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        pix_d = '0;
        for (int k = 0; k < PPC; k++) begin
            pix_d = pixel(mode_q, int'(col_d) * PPC + k, int'(row_d));
            r_d[k*DW +: DW] = state_d == ACTIVE ? pix_d[3*DW-1 -: DW] : '0;
            g_d[k*DW +: DW] = state_d == ACTIVE ? pix_d[2*DW-1 -: DW] : '0;
            b_d[k*DW +: DW] = state_d == ACTIVE ? pix_d[DW-1:0] : '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            hcnt_q    <= '0;
            mode_q    <= '0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
            DATA_R    <= '0;
            DATA_G    <= '0;
            DATA_B    <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hcnt_q    <= hcnt_d;
            mode_q    <= mode_d;
            VSYNC     <= state_d == VS;
            HSYNC     <= state_d == ACTIVE;
            busy      <= state_d inside {VS, ACTIVE, HBL};
            ctrl_done <= state_d == DONE;
            DATA_R    <= r_d;
            DATA_G    <= g_d;
            DATA_B    <= b_d;
        end
    end
endmodule

// File: tb/tb_image_pattern_gen.sv
// tb_image_pattern_gen: compares every output cycle of whole frames against a trace
// built from the pattern rules, under random modes, gaps, resets and stray starts.
module tb_image_pattern_gen;
    localparam int W = 16, H = 9, P = 2, D = 8, HB = 2, COLS = W / P;

    typedef struct packed {
        logic vs, hs, bsy, dn;
        logic [P*D-1:0] r, g, b;
    } obs_t;

    logic HCLK = 1'b0, HRESETn = 1'b1, start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic VSYNC, HSYNC, busy, ctrl_done;
    logic [P*D-1:0] DATA_R, DATA_G, DATA_B;
    obs_t obs;
    obs_t exp_q[$];
    int checks = 0, errors = 0;

    assign obs = {VSYNC, HSYNC, busy, ctrl_done, DATA_R, DATA_G, DATA_B};

    always #5 HCLK = ~HCLK;

    image_pattern_gen #(.IMG_W(W), .IMG_H(H), .PPC(P), .DW(D), .HBLANK(HB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
        .busy(busy), .ctrl_done(ctrl_done)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // c selects the component: 0 = R, 1 = G, 2 = B
    function automatic int comp(input int m, input int c, input int x, input int y);
        int full, bar;
        full = (1 << D) - 1;
        bar  = x / (W / 8);
        if (m == 0) return c == 0 ? x % (1 << D) : c == 1 ? y % (1 << D) : (x + y) % (1 << D);
        if (m == 1) return ((bar >> (2 - c)) % 2) ? full : 0;
        if (m == 2) return ((x / 8 + y / 8) % 2) ? full : 0;
        return 1 << (D - 1);
    endfunction

    function automatic void build(input int m);
        obs_t e;
        exp_q.delete();
        e = '0; e.vs = 1'b1; e.bsy = 1'b1;
        exp_q.push_back(e);
        for (int row = 0; row < H; row++) begin
            for (int col = 0; col < COLS; col++) begin
                e = '0; e.hs = 1'b1; e.bsy = 1'b1;
                for (int k = 0; k < P; k++) begin
                    e.r[k*D +: D] = D'(comp(m, 0, col * P + k, row));
                    e.g[k*D +: D] = D'(comp(m, 1, col * P + k, row));
                    e.b[k*D +: D] = D'(comp(m, 2, col * P + k, row));
                end
                exp_q.push_back(e);
            end
            if (row < H - 1)
                for (int j = 0; j < HB; j++) begin
                    e = '0; e.bsy = 1'b1;
                    exp_q.push_back(e);
                end
        end
        e = '0; e.dn = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        HRESETn = 1'b0;
        start = 1'b1;
        mode = 2'd3;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset cycle %0d: got %h expected 0", i, obs); end
            step();
        end
        start = 1'b0;
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset_idle cycle %0d: got %h expected 0", i, obs); end
        end
    endtask

    task automatic test_gradient();
        build(0);
        start = 1'b1; mode = 2'd0;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL gradient cycle %0d: got %h expected %h", i, obs, exp_q[i]); end
            if (i == 11) begin
                checks++;
                if ({DATA_R, DATA_G, DATA_B} !== 48'h0100_0101_0201) begin
                    errors++; $display("FAIL gradient_line1: got %h expected 010001010201", {DATA_R, DATA_G, DATA_B});
                end
            end
            mode = 2'($urandom);
            step();
        end
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL gradient_idle: got %h expected 0", obs); end
    endtask

    task automatic test_modes();
        int m;
        for (int n = 0; n < 6; n++) begin
            m = n < 3 ? n + 1 : int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) begin
                checks++;
                if (obs !== '0) begin errors++; $display("FAIL modes_gap: got %h expected 0", obs); end
                step();
            end
            build(m);
            start = 1'b1; mode = 2'(m);
            step();
            start = 1'b0;
            foreach (exp_q[i]) begin
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL mode%0d cycle %0d: got %h expected %h", m, i, obs, exp_q[i]); end
                if (m == 1 && (i == 1 || i == 8)) begin
                    checks++;
                    if ({DATA_R, DATA_G, DATA_B} !== (i == 8 ? {48{1'b1}} : 48'h0)) begin
                        errors++; $display("FAIL bars beat %0d: got %h", i - 1, {DATA_R, DATA_G, DATA_B});
                    end
                end
                if (m == 2 && (i == 5 || i == 81 || i == 85)) begin
                    checks++;
                    if (DATA_R[7:0] !== (i == 85 ? 8'h00 : 8'hFF)) begin
                        errors++; $display("FAIL checker cycle %0d: got %h", i, DATA_R[7:0]);
                    end
                end
                mode = 2'($urandom);
                step();
            end
        end
    endtask

    task automatic test_ignore_start();
        build(0);
        start = 1'b1; mode = 2'd0;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL ignore cycle %0d: got %h expected %h", i, obs, exp_q[i]); end
            start = (i == 4 || i == exp_q.size() - 1);
            if (i == 4) mode = 2'd3;
            step();
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL ignore_idle %0d: got %h expected 0", j, obs); end
            step();
        end
        build(3);
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL flat cycle %0d: got %h expected %h", i, obs, exp_q[i]); end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        build(int'($urandom_range(0, 3)));
        start = 1'b1; mode = 2'(exp_q[1].r[0]) == 2'd0 ? 2'd0 : 2'd0;
        build(0);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL abort_pre cycle %0d: got %h expected %h", i, obs, exp_q[i]); end
            if (i < 3) step();
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL abort_async: got %h expected 0", obs); end
        repeat (2) begin
            step();
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL abort_hold: got %h expected 0", obs); end
        end
        HRESETn = 1'b1;
        repeat (4) begin
            step();
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL abort_wait: got %h expected 0", obs); end
        end
        start = 1'b1; mode = 2'd0;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL restart cycle %0d: got %h expected %h", i, obs, exp_q[i]); end
            mode = 2'($urandom);
            step();
        end
    endtask

    task automatic test_back_to_back();
        int m;
        start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            m = int'($urandom_range(0, 3));
            mode = 2'(m);
            build(m);
            step();
            foreach (exp_q[i]) begin
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL b2b frame %0d cycle %0d: got %h expected %h", f, i, obs, exp_q[i]); end
                mode = 2'($urandom);
                step();
            end
            if (f == 2) start = 1'b0;
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL b2b_idle frame %0d: got %h expected 0", f, obs); end
        end
        step();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL b2b_stop: got %h expected 0", obs); end
    endtask

    initial begin
        test_reset();
        test_gradient();
        test_modes();
        test_ignore_start();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
